// File: rtl/seq_pkg.sv
// Shared definitions for the S/T chunk servers: base codes, lane width and FSM states.
package seq_pkg;

    localparam int BASE_W = 2;
    localparam int PE_NUM_DEF = 16;

    typedef enum logic [BASE_W-1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } base_t;

    typedef enum logic {
        LOAD = 1'b0,
        HELD = 1'b1
    } state_t;

endpackage

// File: rtl/seq_chunk_server_if.sv
// Base-stream input and chunk-output handshake of one chunk server.
interface seq_chunk_server_if #(parameter int PE_NUM = seq_pkg::PE_NUM_DEF);

    logic                             i_valid;
    logic                             i_ready;
    logic [seq_pkg::BASE_W-1:0]       i_base;
    logic                             i_last;
    logic                             request;
    logic                             o_ready;
    logic [seq_pkg::BASE_W*PE_NUM-1:0] o_data;
    logic [PE_NUM-1:0]                o_mask;
    logic                             o_last;
    logic                             o_err;
    logic                             replay;

    modport master (
        output i_valid, i_base, i_last, request, replay,
        input  i_ready, o_ready, o_data, o_mask, o_last, o_err
    );

    modport slave (
        input  i_valid, i_base, i_last, request, replay,
        output i_ready, o_ready, o_data, o_mask, o_last, o_err
    );

endinterface

// File: rtl/seq_base_ring.sv
// Base storage ring: one write port and a PE_NUM-lane read window that wraps modulo BUF_DEPTH.
module seq_base_ring
    import seq_pkg::*;
#(
    parameter int PE_NUM    = 16,
    parameter int BUF_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic                       clk,
    input  logic                       wrEn,
    input  logic [AW-1:0]              wrPtr,
    input  logic [BASE_W-1:0]          wrBase,
    input  logic [AW-1:0]              rdPtr,
    output logic [BASE_W*PE_NUM-1:0]   window
);

    logic [BASE_W-1:0] memR [BUF_DEPTH];

    // Store one accepted base per cycle.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            memR[wrPtr] <= wrBase;
        end
    end

    // Gather PE_NUM consecutive bases; the pointer sum wraps naturally in AW bits.
    always_comb begin
        window = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            window[BASE_W*i +: BASE_W] = memR[rdPtr + AW'(i)];
        end
    end

endmodule

// File: rtl/seq_chunk_server.sv
// Chunk server: buffers a base stream and serves PE_NUM-base chunks on request.
// Optional build macro SEQ_CHUNK_REPLAY_EN retains the sequence for replay.
module seq_chunk_server
    import seq_pkg::*;
#(
    parameter int PE_NUM    = 16,
    parameter int BUF_DEPTH = 256,
    parameter int CNT_BIT   = 9
) (
    input logic               clk,
    input logic               rst_n,
    seq_chunk_server_if.slave bus
);

    localparam int AW = $clog2(BUF_DEPTH);

    state_t                     stateR, stateNextS;
    logic [CNT_BIT-1:0]         countR, countNextS, kS;
    logic [AW-1:0]              wrPtrR, rdPtrR;
    logic [BASE_W*PE_NUM-1:0]   windowS, dataNextS, dataR;
    logic [PE_NUM-1:0]          maskNextS, maskR;
    logic                       lastR, errR;
    logic                       pushS, popS, replayS, lastChunkS, oReadyS, iReadyS, errSetS;
`ifdef SEQ_CHUNK_REPLAY_EN
    logic [CNT_BIT-1:0]         loadCntR;
`else
    logic                       unusedReplay;
    assign unusedReplay = bus.replay;
`endif

    seq_base_ring #(.PE_NUM(PE_NUM), .BUF_DEPTH(BUF_DEPTH), .AW(AW)) u_ring (
        .clk    (clk),
        .wrEn   (pushS),
        .wrPtr  (wrPtrR),
        .wrBase (bus.i_base),
        .rdPtr  (rdPtrR),
        .window (windowS)
    );

    // Handshake qualification, pop size and error detection.
    always_comb begin
        kS = (countR >= CNT_BIT'(PE_NUM)) ? CNT_BIT'(PE_NUM) : countR;
        oReadyS = (countR >= CNT_BIT'(PE_NUM)) || ((stateR == HELD) && (countR != '0));
`ifdef SEQ_CHUNK_REPLAY_EN
        // Total loaded length bounds the ring here since pops do not free entries.
        replayS = bus.replay && (stateR == HELD);
        iReadyS = (stateR == LOAD) && (loadCntR < CNT_BIT'(BUF_DEPTH));
        errSetS = (bus.request && !oReadyS) ||
                  ((stateR == LOAD) && bus.i_valid && (loadCntR == CNT_BIT'(BUF_DEPTH)));
`else
        replayS = 1'b0;
        iReadyS = (stateR == LOAD) && (countR < CNT_BIT'(BUF_DEPTH));
        errSetS = bus.request && !oReadyS;
`endif
        pushS      = bus.i_valid && iReadyS;
        popS       = bus.request && oReadyS && !replayS;
        lastChunkS = (stateR == HELD) && (countR == kS);
    end

    // Chunk assembly from pre-edge contents; lanes past k are zeroed.
    always_comb begin
        maskNextS = '0;
        dataNextS = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            maskNextS[i] = (CNT_BIT'(i) < kS);
            dataNextS[BASE_W*i +: BASE_W] = maskNextS[i] ? windowS[BASE_W*i +: BASE_W]
                                                         : {BASE_W{1'b0}};
        end
    end

    // Next state and next occupancy.
    always_comb begin
        stateNextS = stateR;
        countNextS = countR + CNT_BIT'(pushS) - (popS ? kS : CNT_BIT'(0));
        case (stateR)
            LOAD: begin
                if (pushS && bus.i_last) begin
                    stateNextS = HELD;
                end else begin
                    stateNextS = LOAD;
                end
            end
            HELD: begin
`ifdef SEQ_CHUNK_REPLAY_EN
                stateNextS = HELD;
                if (replayS) begin
                    countNextS = loadCntR;
                end else begin
                    countNextS = countNextS;
                end
`else
                if (popS && lastChunkS) begin
                    stateNextS = LOAD;
                end else begin
                    stateNextS = HELD;
                end
`endif
            end
            default: stateNextS = LOAD;
        endcase
    end

    // State, pointers and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateR <= LOAD;
            countR <= '0;
            wrPtrR <= '0;
            rdPtrR <= '0;
            dataR  <= '0;
            maskR  <= '0;
            lastR  <= 1'b0;
            errR   <= 1'b0;
`ifdef SEQ_CHUNK_REPLAY_EN
            loadCntR <= '0;
`endif
        end else begin
            stateR <= stateNextS;
            countR <= countNextS;
            errR   <= errR | errSetS;
            if (pushS) begin
                wrPtrR <= wrPtrR + AW'(1);
            end
            if (replayS) begin
                rdPtrR <= '0;
            end else if (popS) begin
                rdPtrR <= rdPtrR + AW'(kS);
            end
            if (popS) begin
                dataR <= dataNextS;
                maskR <= maskNextS;
                lastR <= lastChunkS;
            end
`ifdef SEQ_CHUNK_REPLAY_EN
            if (pushS) begin
                loadCntR <= loadCntR + CNT_BIT'(1);
            end
`endif
        end
    end

    assign bus.i_ready = iReadyS;
    assign bus.o_ready = oReadyS;
    assign bus.o_data  = dataR;
    assign bus.o_mask  = maskR;
    assign bus.o_last  = lastR;
    assign bus.o_err   = errR;

endmodule
